// File: rtl/ram128k_arbiter.sv
// Two-master arbiter and sequencer for a single-port block RAM with 1-cycle read latency.
// Optionally clears the whole RAM after reset before granting any access.
module ram128k_arbiter #(
  parameter int              AW             = 17,
  parameter int              DW             = 9,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DW-1:0]   CLEAR_VALUE    = '0,
  parameter int              FIXED_PRIO     = 0
) (
  input  logic          clka,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  input  logic [DW-1:0] ram_douta,
  output logic          init_done
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic          rr_last;
  logic          gnt0, gnt1;
  logic          vld0_p1, vld1_p1;

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    case (state)
      CLEAR: begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = clr_cnt;
        ram_dina  = CLEAR_VALUE;
        if (clr_cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        // Nothing is accepted while reset is held, so no read can outlive it.
        if (!reset) begin
          if (m0_req && m1_req) begin
            gnt0 = (FIXED_PRIO != 0) || rr_last;
            gnt1 = !gnt0;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        if (gnt0) begin
          ram_ena   = 1'b1;
          ram_wea   = m0_we;
          ram_addra = m0_addr;
          ram_dina  = m0_wdata;
        end else if (gnt1) begin
          ram_ena   = 1'b1;
          ram_wea   = m1_we;
          ram_addra = m1_addr;
          ram_dina  = m1_wdata;
        end
      end
    endcase
  end

  // Stage p1: RAM read data appears, tagged with the owning master
  always_ff @(posedge clka) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt   <= '0;
      rr_last   <= 1'b1;
      init_done <= 1'b0;
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
      if (gnt0)      rr_last <= 1'b0;
      else if (gnt1) rr_last <= 1'b1;
      init_done <= (state_nxt == RUN);
      vld0_p1   <= gnt0 && !m0_we;
      vld1_p1   <= gnt1 && !m1_we;
    end
  end

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;

  // A read accepted just before reset must not be reported in the reset cycle itself.
  assign m0_rvalid = vld0_p1 && !reset;
  assign m1_rvalid = vld1_p1 && !reset;
  assign m0_rdata  = ram_douta;
  assign m1_rdata  = ram_douta;

endmodule

// File: tb/tb_ram128k_arbiter.sv
// Bench for ram128k_arbiter: a small round-robin instance with clear, and a full-size
// fixed-priority instance without clear, each driving a behavioural RAM.
module tb_ram128k_arbiter;

  localparam int AWA = 4;
  localparam int AWB = 17;
  localparam int DW  = 9;
  localparam logic [DW-1:0] CLR_A = 9'h1A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic           a_rst, a_m0_req, a_m0_we, a_m0_ready, a_m0_rvalid;
  logic [AWA-1:0] a_m0_addr;
  logic [DW-1:0]  a_m0_wdata, a_m0_rdata;
  logic           a_m1_req, a_m1_we, a_m1_ready, a_m1_rvalid;
  logic [AWA-1:0] a_m1_addr;
  logic [DW-1:0]  a_m1_wdata, a_m1_rdata;
  logic           a_ram_ena, a_ram_wea, a_init_done;
  logic [AWA-1:0] a_ram_addra;
  logic [DW-1:0]  a_ram_dina, a_ram_douta;

  logic           b_rst, b_m0_req, b_m0_we, b_m0_ready, b_m0_rvalid;
  logic [AWB-1:0] b_m0_addr;
  logic [DW-1:0]  b_m0_wdata, b_m0_rdata;
  logic           b_m1_req, b_m1_we, b_m1_ready, b_m1_rvalid;
  logic [AWB-1:0] b_m1_addr;
  logic [DW-1:0]  b_m1_wdata, b_m1_rdata;
  logic           b_ram_ena, b_ram_wea, b_init_done;
  logic [AWB-1:0] b_ram_addra;
  logic [DW-1:0]  b_ram_dina, b_ram_douta;

  ram128k_arbiter #(.AW(AWA), .DW(DW), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR_A), .FIXED_PRIO(0)) dut_a (
    .clka(clk), .reset(a_rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_ready(a_m0_ready), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_ready(a_m1_ready), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .ram_ena(a_ram_ena), .ram_wea(a_ram_wea), .ram_addra(a_ram_addra), .ram_dina(a_ram_dina),
    .ram_douta(a_ram_douta), .init_done(a_init_done));

  ram128k_arbiter #(.AW(AWB), .DW(DW), .CLEAR_ON_RESET(0), .CLEAR_VALUE(9'h000), .FIXED_PRIO(1)) dut_b (
    .clka(clk), .reset(b_rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ready(b_m0_ready), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ready(b_m1_ready), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ram_ena(b_ram_ena), .ram_wea(b_ram_wea), .ram_addra(b_ram_addra), .ram_dina(b_ram_dina),
    .ram_douta(b_ram_douta), .init_done(b_init_done));

  // Behavioural single-port RAMs: 1-cycle read latency, write-first
  logic [DW-1:0] mem_a [2**AWA];
  logic [DW-1:0] mem_b [2**AWB];

  always @(posedge clk)
    if (a_ram_ena) begin
      if (a_ram_wea) begin
        mem_a[a_ram_addra] <= a_ram_dina;
        a_ram_douta        <= a_ram_dina;
      end else begin
        a_ram_douta <= mem_a[a_ram_addra];
      end
    end

  always @(posedge clk)
    if (b_ram_ena) begin
      if (b_ram_wea) begin
        mem_b[b_ram_addra] <= b_ram_dina;
        b_ram_douta        <= b_ram_dina;
      end else begin
        b_ram_douta <= mem_b[b_ram_addra];
      end
    end

  // Reference model state for the random phase
  logic [DW-1:0]  mdl_mem [2**AWA];
  logic           pend [2];
  logic           pwe [2];
  logic [AWA-1:0] paddr [2];
  logic [DW-1:0]  pwd [2];
  logic           nxt_rv [2];
  logic [DW-1:0]  nxt_rd [2];
  logic           cur_rv [2];
  logic [DW-1:0]  cur_rd [2];
  int             last_win;
  int             win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_m0_req = 1'b0; a_m0_we = 1'b0; a_m0_addr = '0; a_m0_wdata = '0;
    a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = '0; a_m1_wdata = '0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
    repeat (3) tick();

    // Reset state; m0 already holds a read that must wait for the clear
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 4'd3;
    smp();
    chk("a_rst_init_done", 32'(a_init_done), 32'd0);
    chk("a_rst_m0_rvalid", 32'(a_m0_rvalid), 32'd0);
    chk("a_rst_m1_rvalid", 32'(a_m1_rvalid), 32'd0);
    chk("a_rst_m0_ready", 32'(a_m0_ready), 32'd0);
    chk("b_rst_init_done", 32'(b_init_done), 32'd0);
    chk("b_rst_m0_rvalid", 32'(b_m0_rvalid), 32'd0);

    // Clear sequence: 16 writes of CLEAR_VALUE to addresses 0..15
    tick();
    a_rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      smp();
      chk("clr_ena", 32'(a_ram_ena), 32'd1);
      chk("clr_wea", 32'(a_ram_wea), 32'd1);
      chk("clr_addr", 32'(a_ram_addra), 32'(k));
      chk("clr_din", 32'(a_ram_dina), 32'(CLR_A));
      chk("clr_m0_ready", 32'(a_m0_ready), 32'd0);
      chk("clr_init_done", 32'(a_init_done), 32'd0);
      tick();
    end
    smp();
    chk("run_init_done", 32'(a_init_done), 32'd1);
    chk("run_m0_ready", 32'(a_m0_ready), 32'd1);
    chk("run_ram_wea", 32'(a_ram_wea), 32'd0);
    chk("run_ram_addr", 32'(a_ram_addra), 32'd3);
    tick();
    a_m0_req = 1'b0;
    smp();
    chk("clr_rd_rvalid", 32'(a_m0_rvalid), 32'd1);
    chk("clr_rd_rdata", 32'(a_m0_rdata), 32'(CLR_A));
    chk("clr_rd_m1_rvalid", 32'(a_m1_rvalid), 32'd0);

    // Random two-master traffic against the reference model
    for (int i = 0; i < 2**AWA; i++) mdl_mem[i] = CLR_A;
    last_win = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; pwe[m] = 1'b0; paddr[m] = '0; pwd[m] = '0;
      nxt_rv[m] = 1'b0; nxt_rd[m] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int m = 0; m < 2; m++)
        if (!pend[m] && cyc < 390 && $urandom_range(3) != 0) begin
          pend[m]  = 1'b1;
          pwe[m]   = 1'($urandom_range(1));
          paddr[m] = AWA'($urandom_range(2**AWA - 1));
          pwd[m]   = DW'($urandom_range(511));
        end
      a_m0_req = pend[0]; a_m0_we = pwe[0]; a_m0_addr = paddr[0]; a_m0_wdata = pwd[0];
      a_m1_req = pend[1]; a_m1_we = pwe[1]; a_m1_addr = paddr[1]; a_m1_wdata = pwd[1];
      if (pend[0] && pend[1]) win = (last_win == 0) ? 1 : 0;
      else if (pend[0])       win = 0;
      else if (pend[1])       win = 1;
      else                    win = -1;
      for (int m = 0; m < 2; m++) begin
        cur_rv[m] = nxt_rv[m];
        cur_rd[m] = nxt_rd[m];
      end
      smp();
      chk("rnd_m0_ready", 32'(a_m0_ready), 32'(win == 0));
      chk("rnd_m1_ready", 32'(a_m1_ready), 32'(win == 1));
      chk("rnd_ram_ena", 32'(a_ram_ena), 32'(win >= 0));
      if (win >= 0) begin
        chk("rnd_ram_wea", 32'(a_ram_wea), 32'(pwe[win]));
        chk("rnd_ram_addr", 32'(a_ram_addra), 32'(paddr[win]));
        chk("rnd_ram_din", 32'(a_ram_dina), 32'(pwd[win]));
      end else begin
        chk("idle_ram_wea", 32'(a_ram_wea), 32'd0);
        chk("idle_ram_addr", 32'(a_ram_addra), 32'd0);
        chk("idle_ram_din", 32'(a_ram_dina), 32'd0);
      end
      chk("rnd_m0_rvalid", 32'(a_m0_rvalid), 32'(cur_rv[0]));
      chk("rnd_m1_rvalid", 32'(a_m1_rvalid), 32'(cur_rv[1]));
      if (cur_rv[0]) chk("rnd_m0_rdata", 32'(a_m0_rdata), 32'(cur_rd[0]));
      if (cur_rv[1]) chk("rnd_m1_rdata", 32'(a_m1_rdata), 32'(cur_rd[1]));
      nxt_rv[0] = 1'b0;
      nxt_rv[1] = 1'b0;
      if (win >= 0) begin
        if (pwe[win]) mdl_mem[paddr[win]] = pwd[win];
        else begin
          nxt_rv[win] = 1'b1;
          nxt_rd[win] = mdl_mem[paddr[win]];
        end
        pend[win] = 1'b0;
        last_win  = win;
      end
    end

    // Read accepted, then reset on the next cycle: rvalid suppressed, clear restarts at 0
    tick();
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 4'd7;
    a_m1_req = 1'b0;
    smp();
    chk("mid_rd_ready", 32'(a_m0_ready), 32'd1);
    tick();
    a_m0_req = 1'b0; a_rst = 1'b1;
    smp();
    chk("mid_rst_rvalid_n1", 32'(a_m0_rvalid), 32'd0);
    tick();
    a_rst = 1'b0;
    smp();
    chk("mid_rst_rvalid_n2", 32'(a_m0_rvalid), 32'd0);
    chk("mid_rst_init_done", 32'(a_init_done), 32'd0);
    chk("mid_rst_clr_addr0", 32'(a_ram_addra), 32'd0);
    chk("mid_rst_clr_wea", 32'(a_ram_wea), 32'd1);
    for (int k = 1; k < 16; k++) begin
      tick();
      smp();
      chk("mid_rst_clr_addr", 32'(a_ram_addra), 32'(k));
    end
    tick();
    smp();
    chk("mid_rst_init_done_again", 32'(a_init_done), 32'd1);

    // Full-size instance, no clear, fixed priority
    tick();
    b_rst = 1'b0;
    smp();
    chk("b_init_done_r0", 32'(b_init_done), 32'd0);
    tick();
    b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 17'd5; b_m1_wdata = 9'h055;
    smp();
    chk("b_init_done_r1", 32'(b_init_done), 32'd1);
    chk("b_m1_wr_ready", 32'(b_m1_ready), 32'd1);
    chk("b_m1_wr_ena", 32'(b_ram_ena), 32'd1);
    chk("b_m1_wr_wea", 32'(b_ram_wea), 32'd1);
    chk("b_m1_wr_addr", 32'(b_ram_addra), 32'd5);
    chk("b_m1_wr_din", 32'(b_ram_dina), 32'h055);
    tick();
    b_m1_we = 1'b0;
    smp();
    chk("b_m1_rd_ready", 32'(b_m1_ready), 32'd1);
    chk("b_m1_rd_wea", 32'(b_ram_wea), 32'd0);
    tick();
    b_m1_req = 1'b0;
    b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 17'h1F000; b_m0_wdata = 9'h0AB;
    smp();
    chk("b_m1_rvalid", 32'(b_m1_rvalid), 32'd1);
    chk("b_m1_rdata", 32'(b_m1_rdata), 32'h055);
    chk("b_m0_wr_ready", 32'(b_m0_ready), 32'd1);
    chk("b_m0_wr_addr", 32'(b_ram_addra), 32'h1F000);
    chk("b_m0_wr_din", 32'(b_ram_dina), 32'h0AB);
    tick();
    b_m0_we = 1'b0;
    smp();
    chk("b_m0_rd_ready", 32'(b_m0_ready), 32'd1);
    chk("b_m0_wr_no_rvalid", 32'(b_m0_rvalid), 32'd0);
    tick();
    b_m1_req = 1'b1; b_m1_we = 1'b0; b_m1_addr = 17'd5;
    smp();
    chk("b_raw_rvalid", 32'(b_m0_rvalid), 32'd1);
    chk("b_raw_rdata", 32'(b_m0_rdata), 32'h0AB);
    chk("b_raw_m1_rvalid", 32'(b_m1_rvalid), 32'd0);
    chk("b_fix_m0_ready", 32'(b_m0_ready), 32'd1);
    chk("b_fix_m1_ready", 32'(b_m1_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      smp();
      chk("b_fix_m0_ready", 32'(b_m0_ready), 32'd1);
      chk("b_fix_m1_ready", 32'(b_m1_ready), 32'd0);
      chk("b_fix_m0_rvalid", 32'(b_m0_rvalid), 32'd1);
      chk("b_fix_m0_rdata", 32'(b_m0_rdata), 32'h0AB);
      chk("b_fix_m1_rvalid", 32'(b_m1_rvalid), 32'd0);
    end
    tick();
    b_m0_req = 1'b0;
    smp();
    chk("b_drop_m1_ready", 32'(b_m1_ready), 32'd1);
    chk("b_drop_m0_ready", 32'(b_m0_ready), 32'd0);
    chk("b_drop_m0_rvalid", 32'(b_m0_rvalid), 32'd1);
    tick();
    b_m1_req = 1'b0;
    smp();
    chk("b_last_m1_rvalid", 32'(b_m1_rvalid), 32'd1);
    chk("b_last_m1_rdata", 32'(b_m1_rdata), 32'h055);
    chk("b_last_m0_rvalid", 32'(b_m0_rvalid), 32'd0);
    tick();
    smp();
    chk("b_idle_m1_rvalid", 32'(b_m1_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
